cmd_array_parser: RTL and testbench
===================================

# cmd_array_parser

Receives host-issued command packets on the 134-bit FPGA-OS packet stream and decodes them into the command array that drives PGM, FSM and SSM. It is the downstream counterpart of the periodic command/state report: the command packet carries the same word layout as the report's command-array section. The block sits between the FPGA-OS receive path and the test-control registers. Fields are applied atomically only after a complete, well-formed packet has been received.

## Interface
- Parameters: PLATFORM, "xilinx", target selection only; no functional effect.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cnt_rst  in  1  sync clear of both packet counters.
- in_data  in  134  packet word. [133:132] = 01 first, 11 middle, 10 last; [131:128] ignored; [127:0] payload.
- in_data_wr  in  1  in_data valid this cycle.
- in_data_valid  in  1  packet-good flag; sampled only when in_data_valid_wr=1.
- in_data_valid_wr  in  1  strobe for in_data_valid.
- out_test_start, out_test_stop  out  1 each  command levels.
- out_gcl_time_slot_cycle  out  20  GCL cycle.
- out_tb_size, out_tb_rate  out  128 each  entry i (1..8) at [16i-1:16i-16].
- out_pkt_len  out  96  entry i at [12i-1:12i-12].
- out_rule_5tuple, out_mask  out  832 each  entry i at [104i-1:104i-104].
- out_samp_freq  out  16  SSM sampling frequency.
- out_cfg_update  out  1  one-cycle pulse when a new command array has been applied.
- out_good_pkt_cnt, out_bad_pkt_cnt  out  32 each  accepted and rejected packet counts; wrap at 2^32.

## Operation
- Word index w counts accepted words from 0 (the 01 word). A packet is exactly 30 words, w0..w29.
- w0 and w1 are metadata; w3 and w4 are encapsulated metadata. All four are ignored.
- w2 is the Ethernet header. [31:16] must equal 16'hFF01 and [15:12] must equal 4'h1; any other value makes the packet bad. MACs and [11:0] are ignored.
- w5: [19:0] gcl cycle, [32] test_stop, [33] test_start.
- w6: tb1 rate [15:0], tb1 size [31:16], tb2 rate [47:32], tb2 size [63:48], tb3 rate [79:64], tb3 size [95:80].
- w7: tb4..tb6, same layout as w6.
- w8: tb7 in [31:0], tb8 in [63:32], same rate/size order.
- w9: pkt_len i at [16i-5:16i-16].
- w10, w27, w29 are pad.
- w11..w26 alternate rule i then mask i, for i = 1..8, each in [103:0].
- w28: samp_freq [15:0].
- Decoded fields are written into shadow registers. Outputs change only at commit.

State machine:
- IDLE:
  - A 01 word goes to RECV with w=0.
  - 11 and 10 words are dropped silently, with no count.
- RECV, on each in_data_wr:
  - A 01 word: bad_cnt+1, restart at w=0 (stay in RECV).
  - A 10 word at w=29 with in_data_valid_wr=1, in_data_valid=1 and a good header: commit, good_cnt+1, go to IDLE.
  - Any other 10 word: bad_cnt+1, go to IDLE.
  - An 11 word at w=29: bad_cnt+1, go to DISCARD.
  - A bad header at w2: go to DISCARD (counted there).
- DISCARD:
  - Drops words until a 10 word, then bad_cnt+1 and go to IDLE.
  - A 01 word: bad_cnt+1, go to RECV with w=0.
- cnt_rst clears both counters. If cnt_rst coincides with an increment, the clear wins.
- A reset mid-packet returns the block to IDLE, clears shadows and outputs, and produces no commit.

## Timing
- Reset value of every output is 0.
- Commit latency: all command outputs update and out_cfg_update pulses in the cycle after the accepted w29 edge. Counters update in that same cycle.
- Cycles with in_data_wr=0 are stalls: w holds, with no timeout.
- A new 01 word may arrive the cycle after a 10 word. Back-to-back packets must each be processed.
- Shadow writes for a rejected packet never reach the outputs.

## Test plan
- Legal 30-word packet: gcl=20'h12345, test_start=1, tb3 rate/size=16'h0A0B/16'h0C0D, pkt_len8=12'h5EE, rule8=104'hAB…, samp_freq=16'd1000 -> one out_cfg_update pulse the cycle after w29; all fields match; good_cnt=1, bad_cnt=0.
- Same packet with ethertype 16'h0800 -> no update; bad_cnt=1; outputs unchanged.
- Packet truncated (10 word at w=20), then a legal packet back-to-back -> bad_cnt=1, then good_cnt=1 with the second packet's values.
- Legal packet with in_data_valid=0 on the last word -> rejected; bad_cnt=1.
- Stray 11/10 words in IDLE, then 01 mid-packet -> the stray words are not counted; the restart counts bad_cnt=1; the following packet is accepted.
- rst_n asserted at w=15, then cnt_rst coinciding with a bad-packet increment -> all outputs 0 after reset; bad_cnt reads 0.

Source files
------------

// File: rtl/cmd_array_parser.sv
// Decodes 30-word host command packets from the FPGA-OS stream into the PGM/FSM/SSM
// command array; fields land in shadow registers and reach the outputs only on commit.
module cmd_array_parser #(
    parameter string PLATFORM = "xilinx"
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cnt_rst,
    input  logic [133:0] in_data,
    input  logic         in_data_wr,
    input  logic         in_data_valid,
    input  logic         in_data_valid_wr,
    output logic         out_test_start,
    output logic         out_test_stop,
    output logic [19:0]  out_gcl_time_slot_cycle,
    output logic [127:0] out_tb_size,
    output logic [127:0] out_tb_rate,
    output logic [95:0]  out_pkt_len,
    output logic [831:0] out_rule_5tuple,
    output logic [831:0] out_mask,
    output logic [15:0]  out_samp_freq,
    output logic         out_cfg_update,
    output logic [31:0]  out_good_pkt_cnt,
    output logic [31:0]  out_bad_pkt_cnt
);

    localparam int unsigned N_ENT  = 8;
    localparam int unsigned TB_W   = 16;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned RULE_W = 104;
    localparam int unsigned GCL_W  = 20;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned IDX_W  = 5;

    localparam logic [IDX_W-1:0] W_HDR  = 5'd2;
    localparam logic [IDX_W-1:0] W_CTRL = 5'd5;
    localparam logic [IDX_W-1:0] W_TB0  = 5'd6;
    localparam logic [IDX_W-1:0] W_TB1  = 5'd7;
    localparam logic [IDX_W-1:0] W_TB2  = 5'd8;
    localparam logic [IDX_W-1:0] W_LEN  = 5'd9;
    localparam logic [IDX_W-1:0] W_RULE = 5'd11;
    localparam logic [IDX_W-1:0] W_SAMP = 5'd28;
    localparam logic [IDX_W-1:0] W_LAST = 5'd29;

    localparam logic [1:0] K_FIRST = 2'b01;
    localparam logic [1:0] K_LAST  = 2'b10;

    localparam bit unused_platform = (PLATFORM == "xilinx");

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] w, w_next;
    logic             store_c, commit_c, good_inc_c, bad_inc_c;

    logic [1:0]   kind;
    logic [127:0] payload;
    logic         hdr_ok, last_ok;
    logic         unused_bits;

    logic                    sh_start, sh_stop;
    logic [GCL_W-1:0]        sh_gcl;
    logic [N_ENT*TB_W-1:0]   sh_size, sh_rate;
    logic [N_ENT*LEN_W-1:0]  sh_len;
    logic [N_ENT*RULE_W-1:0] sh_rule, sh_mask;
    logic [TB_W-1:0]         sh_samp;

    assign kind        = in_data[133:132];
    assign payload     = in_data[127:0];
    assign hdr_ok      = (payload[31:16] == 16'hFF01) && (payload[15:12] == 4'h1);
    assign last_ok     = in_data_valid_wr && in_data_valid;
    assign unused_bits = ^{in_data[131:128], payload[127:124], payload[111:108]};

    // w is the index of the word the next accepted edge will consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            w     <= '0;
        end else begin
            state <= state_next;
            w     <= w_next;
        end
    end

    always_comb begin
        state_next = state;
        w_next     = w;
        store_c    = 1'b0;
        commit_c   = 1'b0;
        good_inc_c = 1'b0;
        bad_inc_c  = 1'b0;
        if (in_data_wr) begin
            unique case (state)
                IDLE: begin
                    if (kind == K_FIRST) begin
                        state_next = RECV;
                        w_next     = IDX_W'(1);
                    end
                end
                RECV: begin
                    if (kind == K_FIRST) begin
                        bad_inc_c = 1'b1;
                        w_next    = IDX_W'(1);
                    end else if (kind == K_LAST) begin
                        state_next = IDLE;
                        if (w == W_LAST && last_ok) begin
                            commit_c   = 1'b1;
                            good_inc_c = 1'b1;
                        end else begin
                            bad_inc_c = 1'b1;
                        end
                    end else if (w == W_LAST) begin
                        bad_inc_c  = 1'b1;
                        state_next = DISCARD;
                    end else if (w == W_HDR && !hdr_ok) begin
                        state_next = DISCARD;
                    end else begin
                        store_c = 1'b1;
                        w_next  = w + IDX_W'(1);
                    end
                end
                DISCARD: begin
                    if (kind == K_FIRST) begin
                        bad_inc_c  = 1'b1;
                        state_next = RECV;
                        w_next     = IDX_W'(1);
                    end else if (kind == K_LAST) begin
                        bad_inc_c  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Shadow capture of command fields, keyed by word index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_start <= 1'b0;
            sh_stop  <= 1'b0;
            sh_gcl   <= '0;
            sh_size  <= '0;
            sh_rate  <= '0;
            sh_len   <= '0;
            sh_rule  <= '0;
            sh_mask  <= '0;
            sh_samp  <= '0;
        end else if (store_c) begin
            if (w == W_CTRL) begin
                sh_gcl   <= payload[GCL_W-1:0];
                sh_stop  <= payload[32];
                sh_start <= payload[33];
            end
            for (int j = 0; j < 3; j++) begin
                if (w == W_TB0) begin
                    sh_rate[TB_W*j +: TB_W] <= payload[2*TB_W*j +: TB_W];
                    sh_size[TB_W*j +: TB_W] <= payload[2*TB_W*j+TB_W +: TB_W];
                end
                if (w == W_TB1) begin
                    sh_rate[TB_W*(j+3) +: TB_W] <= payload[2*TB_W*j +: TB_W];
                    sh_size[TB_W*(j+3) +: TB_W] <= payload[2*TB_W*j+TB_W +: TB_W];
                end
                if (w == W_TB2 && j < 2) begin
                    sh_rate[TB_W*(j+6) +: TB_W] <= payload[2*TB_W*j +: TB_W];
                    sh_size[TB_W*(j+6) +: TB_W] <= payload[2*TB_W*j+TB_W +: TB_W];
                end
            end
            for (int j = 0; j < int'(N_ENT); j++) begin
                if (w == W_LEN)
                    sh_len[LEN_W*j +: LEN_W] <= payload[TB_W*j +: LEN_W];
                if (w == IDX_W'(int'(W_RULE) + 2*j))
                    sh_rule[RULE_W*j +: RULE_W] <= payload[RULE_W-1:0];
                if (w == IDX_W'(int'(W_RULE) + 2*j + 1))
                    sh_mask[RULE_W*j +: RULE_W] <= payload[RULE_W-1:0];
            end
            if (w == W_SAMP)
                sh_samp <= payload[TB_W-1:0];
        end
    end

    // Atomic transfer of the whole command array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_test_start          <= 1'b0;
            out_test_stop           <= 1'b0;
            out_gcl_time_slot_cycle <= '0;
            out_tb_size             <= '0;
            out_tb_rate             <= '0;
            out_pkt_len             <= '0;
            out_rule_5tuple         <= '0;
            out_mask                <= '0;
            out_samp_freq           <= '0;
            out_cfg_update          <= 1'b0;
        end else begin
            out_cfg_update <= commit_c;
            if (commit_c) begin
                out_test_start          <= sh_start;
                out_test_stop           <= sh_stop;
                out_gcl_time_slot_cycle <= sh_gcl;
                out_tb_size             <= sh_size;
                out_tb_rate             <= sh_rate;
                out_pkt_len             <= sh_len;
                out_rule_5tuple         <= sh_rule;
                out_mask                <= sh_mask;
                out_samp_freq           <= sh_samp;
            end
        end
    end

    // Packet counters; a clear overrides a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_good_pkt_cnt <= '0;
            out_bad_pkt_cnt  <= '0;
        end else if (cnt_rst) begin
            out_good_pkt_cnt <= '0;
            out_bad_pkt_cnt  <= '0;
        end else begin
            if (good_inc_c) out_good_pkt_cnt <= out_good_pkt_cnt + CNT_W'(1);
            if (bad_inc_c)  out_bad_pkt_cnt  <= out_bad_pkt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cmd_array_parser.sv
// Randomized scoreboard bench for cmd_array_parser: the stimulus side queues expected
// commits built from a field-level packet model, a monitor checks every cfg_update pulse.
module tb_cmd_array_parser;

    logic         clk = 1'b0;
    logic         rst_n, cnt_rst;
    logic [133:0] in_data;
    logic         in_data_wr, in_data_valid, in_data_valid_wr;
    logic         out_test_start, out_test_stop, out_cfg_update;
    logic [19:0]  out_gcl_time_slot_cycle;
    logic [127:0] out_tb_size, out_tb_rate;
    logic [95:0]  out_pkt_len;
    logic [831:0] out_rule_5tuple, out_mask;
    logic [15:0]  out_samp_freq;
    logic [31:0]  out_good_pkt_cnt, out_bad_pkt_cnt;

    always #5 clk = ~clk;

    cmd_array_parser #(.PLATFORM("xilinx")) dut (
        .clk(clk), .rst_n(rst_n), .cnt_rst(cnt_rst),
        .in_data(in_data), .in_data_wr(in_data_wr),
        .in_data_valid(in_data_valid), .in_data_valid_wr(in_data_valid_wr),
        .out_test_start(out_test_start), .out_test_stop(out_test_stop),
        .out_gcl_time_slot_cycle(out_gcl_time_slot_cycle),
        .out_tb_size(out_tb_size), .out_tb_rate(out_tb_rate),
        .out_pkt_len(out_pkt_len), .out_rule_5tuple(out_rule_5tuple),
        .out_mask(out_mask), .out_samp_freq(out_samp_freq),
        .out_cfg_update(out_cfg_update),
        .out_good_pkt_cnt(out_good_pkt_cnt), .out_bad_pkt_cnt(out_bad_pkt_cnt)
    );

    // Command array at field level; entry i+1 lives at element [i]
    typedef struct packed {
        logic              start;
        logic              stop;
        logic [19:0]       gcl;
        logic [7:0][15:0]  rate;
        logic [7:0][15:0]  size;
        logic [7:0][11:0]  len;
        logic [7:0][103:0] rule;
        logic [7:0][103:0] mask;
        logic [15:0]       samp;
    } cmd_t;

    typedef struct {
        cmd_t c;
        int   due;
    } exp_t;

    localparam logic [1:0] K_FIRST = 2'b01;
    localparam logic [1:0] K_MID   = 2'b11;
    localparam logic [1:0] K_LAST  = 2'b10;

    exp_t         exp_q[$];
    int           n_total = 0, n_bad = 0, cyc = 0;
    int           exp_good = 0, exp_bad = 0, stall_max = 0;
    cmd_t         last_cmd;
    logic [127:0] pw [30];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.start = 1'($urandom);
        c.stop  = 1'($urandom);
        c.gcl   = 20'($urandom);
        for (int i = 0; i < 8; i++) begin
            c.rate[i] = 16'($urandom);
            c.size[i] = 16'($urandom);
            c.len[i]  = 12'($urandom);
            c.rule[i] = {8'($urandom), $urandom, $urandom, $urandom};
            c.mask[i] = {8'($urandom), $urandom, $urandom, $urandom};
        end
        c.samp = 16'($urandom);
        return c;
    endfunction

    task automatic cmp(input string name, input logic [831:0] act, input logic [831:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input cmd_t c);
        cmp("test_start", 832'(out_test_start), 832'(c.start));
        cmp("test_stop", 832'(out_test_stop), 832'(c.stop));
        cmp("gcl", 832'(out_gcl_time_slot_cycle), 832'(c.gcl));
        cmp("tb_rate", 832'(out_tb_rate), 832'(c.rate));
        cmp("tb_size", 832'(out_tb_size), 832'(c.size));
        cmp("pkt_len", 832'(out_pkt_len), 832'(c.len));
        cmp("rule", out_rule_5tuple, c.rule);
        cmp("mask", out_mask, c.mask);
        cmp("samp_freq", 832'(out_samp_freq), 832'(c.samp));
    endtask

    // Lay the command out in packet words; unused bits and pad words carry noise
    task automatic build(input cmd_t c, input int eth_mode);
        logic [127:0] p;
        for (int w = 0; w < 30; w++) pw[w] = rand128();
        p = pw[2];
        p[31:16] = 16'hFF01;
        p[15:12] = 4'h1;
        if (eth_mode == 1) p[31:16] = 16'h0800;
        if (eth_mode == 2) begin
            if ($urandom_range(0, 1) == 0) p[31:16] = 16'hFF01 ^ 16'($urandom_range(1, 65535));
            else p[15:12] = 4'h1 ^ 4'($urandom_range(1, 15));
        end
        pw[2] = p;
        pw[5][19:0] = c.gcl;
        pw[5][32]   = c.stop;
        pw[5][33]   = c.start;
        for (int j = 0; j < 3; j++) begin
            pw[6][32*j +: 16]    = c.rate[j];
            pw[6][32*j+16 +: 16] = c.size[j];
            pw[7][32*j +: 16]    = c.rate[j+3];
            pw[7][32*j+16 +: 16] = c.size[j+3];
        end
        for (int j = 0; j < 2; j++) begin
            pw[8][32*j +: 16]    = c.rate[j+6];
            pw[8][32*j+16 +: 16] = c.size[j+6];
        end
        for (int j = 0; j < 8; j++) begin
            pw[9][16*j +: 12]     = c.len[j];
            pw[11+2*j][103:0]     = c.rule[j];
            pw[12+2*j][103:0]     = c.mask[j];
        end
        pw[28][15:0] = c.samp;
    endtask

    task automatic send_word(input logic [1:0] k, input logic [127:0] p, input logic vwr, input logic v);
        int s;
        s = (stall_max > 0) ? $urandom_range(0, stall_max) : 0;
        repeat (s) begin
            @(negedge clk);
            in_data          = {K_MID, 4'($urandom), rand128()};
            in_data_wr       = 1'b0;
            in_data_valid_wr = 1'($urandom);
            in_data_valid    = 1'($urandom);
        end
        @(negedge clk);
        in_data          = {k, 4'($urandom), p};
        in_data_wr       = 1'b1;
        in_data_valid_wr = vwr;
        in_data_valid    = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_data_wr       = 1'b0;
            in_data_valid_wr = 1'b0;
        end
    endtask

    task automatic send_prefix(input int n);
        build(rand_cmd(), 0);
        for (int w = 0; w < n; w++)
            send_word((w == 0) ? K_FIRST : K_MID, pw[w], 1'($urandom), 1'($urandom));
    endtask

    // trunc_at>0: a last word ends the packet at that index; long: an 11 word sits at w29
    task automatic send_pkt(input cmd_t c, input int eth_mode, input int trunc_at,
                            input logic vwr, input logic v, input bit long_pkt);
        bit good;
        build(c, eth_mode);
        good = (eth_mode == 0) && (trunc_at <= 0) && !long_pkt && vwr && v;
        for (int w = 0; w < 30; w++) begin
            if (w == trunc_at) begin
                send_word(K_LAST, pw[w], 1'b1, 1'b1);
                break;
            end else if (w == 29) begin
                if (long_pkt) begin
                    send_word(K_MID, pw[29], 1'b1, 1'b1);
                    send_word(K_LAST, rand128(), 1'b1, 1'b1);
                end else begin
                    send_word(K_LAST, pw[29], vwr, v);
                end
            end else begin
                send_word((w == 0) ? K_FIRST : K_MID, pw[w], 1'($urandom), 1'($urandom));
            end
        end
        if (good) begin
            exp_q.push_back('{c: c, due: cyc + 1});
            exp_good++;
            last_cmd = c;
        end else begin
            exp_bad += (long_pkt && eth_mode == 0) ? 2 : 1;
        end
    endtask

    task automatic check_counts(input string tag);
        idle(2);
        cmp({tag, "_good_cnt"}, 832'(out_good_pkt_cnt), 832'(32'(exp_good)));
        cmp({tag, "_bad_cnt"}, 832'(out_bad_pkt_cnt), 832'(32'(exp_bad)));
    endtask

    // Monitor: every pulse must match the oldest queued commit at the promised cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_cfg_update) begin
                if (exp_q.size() == 0) begin
                    cmp("cfg_update_unexpected", 832'(out_cfg_update), 832'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    cmp("commit_cycle", 832'(cyc), 832'(e.due));
                    check_outputs(e.c);
                end
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
                cmp("cfg_update_missing", 832'(out_cfg_update), 832'(1));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c;
        int   k;
        rst_n = 1'b0; cnt_rst = 1'b0; in_data = '0;
        in_data_wr = 1'b0; in_data_valid = 1'b0; in_data_valid_wr = 1'b0;
        last_cmd = '0;
        repeat (3) @(negedge clk);
        check_outputs('0);
        cmp("rst_cfg_update", 832'(out_cfg_update), 832'(0));
        rst_n = 1'b1;
        check_counts("reset");

        // Directed legal packet
        c = rand_cmd();
        c.gcl = 20'h12345; c.start = 1'b1; c.stop = 1'b0;
        c.rate[2] = 16'h0A0B; c.size[2] = 16'h0C0D;
        c.len[7] = 12'h5EE; c.rule[7] = {13{8'hAB}}; c.samp = 16'd1000;
        send_pkt(c, 0, -1, 1'b1, 1'b1, 1'b0);
        check_counts("legal");
        check_outputs(last_cmd);

        // Wrong ethertype
        c.gcl = 20'h54321;
        send_pkt(c, 1, -1, 1'b1, 1'b1, 1'b0);
        check_counts("ethertype");
        check_outputs(last_cmd);

        // Truncated packet followed back-to-back by a legal one
        send_pkt(rand_cmd(), 0, 20, 1'b1, 1'b1, 1'b0);
        send_pkt(rand_cmd(), 0, -1, 1'b1, 1'b1, 1'b0);
        check_counts("trunc_b2b");
        check_outputs(last_cmd);

        // Last word flagged not valid
        send_pkt(rand_cmd(), 0, -1, 1'b1, 1'b0, 1'b0);
        check_counts("invalid_last");
        check_outputs(last_cmd);

        // Stray words in IDLE, then a restart mid-packet
        send_word(K_MID, rand128(), 1'b1, 1'b1);
        send_word(K_LAST, rand128(), 1'b1, 1'b1);
        idle(2);
        send_prefix(12);
        exp_bad++;
        send_pkt(rand_cmd(), 0, -1, 1'b1, 1'b1, 1'b0);
        check_counts("stray_restart");

        // Randomized traffic with stalls, restarts and every rejection kind
        stall_max = 2;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_word(($urandom_range(0, 1) == 0) ? K_MID : K_LAST, rand128(), 1'b1, 1'b1);
            end
            if ($urandom_range(0, 3) == 0) begin
                send_prefix($urandom_range(1, 28));
                exp_bad++;
            end
            k = $urandom_range(0, 7);
            case (k)
                4: send_pkt(rand_cmd(), 2, -1, 1'b1, 1'b1, 1'b0);
                5: send_pkt(rand_cmd(), 0, $urandom_range(1, 28), 1'b1, 1'b1, 1'b0);
                6: begin
                    int r;
                    r = $urandom_range(0, 2);
                    send_pkt(rand_cmd(), 0, -1, 1'(r >> 1), 1'(r), 1'b0);
                end
                7: send_pkt(rand_cmd(), $urandom_range(0, 1) * 2, -1, 1'b1, 1'b1, 1'b1);
                default: send_pkt(rand_cmd(), 0, -1, 1'b1, 1'b1, 1'b0);
            endcase
            idle($urandom_range(0, 2));
        end
        check_counts("random");
        check_outputs(last_cmd);
        stall_max = 0;

        // Reset mid-packet
        send_prefix(15);
        @(negedge clk);
        rst_n = 1'b0;
        in_data_wr = 1'b0;
        exp_good = 0; exp_bad = 0; last_cmd = '0;
        idle(2);
        check_outputs('0);
        cmp("mid_rst_good_cnt", 832'(out_good_pkt_cnt), 832'(0));
        cmp("mid_rst_bad_cnt", 832'(out_bad_pkt_cnt), 832'(0));
        rst_n = 1'b1;
        idle(2);
        check_outputs('0);

        // Counter clear coinciding with a bad-packet increment
        send_prefix(5);
        @(negedge clk);
        in_data    = {K_LAST, 4'h0, rand128()};
        in_data_wr = 1'b1;
        cnt_rst    = 1'b1;
        @(negedge clk);
        cnt_rst    = 1'b0;
        in_data_wr = 1'b0;
        check_counts("cnt_rst");
        send_pkt(rand_cmd(), 0, -1, 1'b1, 1'b1, 1'b0);
        check_counts("after_clear");
        check_outputs(last_cmd);

        idle(3);
        cmp("queue_drained", 832'(exp_q.size()), 832'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
